// File: rtl/mux_pkg.sv
// Shared definitions for the selector family: select-width helper, PC
// constants, the select encodings of the existing PC/Rd selectors, and the
// occupancy encoding of the skid buffer.
package mux_pkg;

  // Select width for an n-way selector, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam logic [31:0] PC_EXC_VECTOR   = 32'h0040_0004;
  localparam logic [31:0] PC_RESET_VECTOR = 32'h0040_0000;

  // Next-PC source select used by the fetch stage.
  typedef enum logic [2:0] {
    PC_SEL_PLUS4  = 3'd0,
    PC_SEL_BRANCH = 3'd1,
    PC_SEL_JUMP   = 3'd2,
    PC_SEL_JR     = 3'd3,
    PC_SEL_EPC    = 3'd4,
    PC_SEL_EXC    = 3'd5
  } pc_sel_e;

  // Destination register select used by decode/writeback.
  typedef enum logic [1:0] {
    RD_SEL_RT = 2'd0,
    RD_SEL_RD = 2'd1,
    RD_SEL_RA = 2'd2
  } rd_sel_e;

  // Skid buffer occupancy.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_FULL1 = 2'd1,
    SKID_FULL2 = 2'd2
  } skid_state_e;

endpackage

// File: rtl/mux_skid_buf.sv
// Generic 2-entry skid buffer with synchronous flush.
// Handshake: a word moves on an interface only in a cycle where valid and
// ready are both high; valid never depends on ready, and in_ready comes from
// registered state only, so there is no combinational path out_ready->in_ready.
// The occupancy FSM is visible on state_dbg.
module mux_skid_buf
  import mux_pkg::*;
#(
  parameter int            DW        = 33,
  parameter logic [DW-1:0] RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output skid_state_e   state_dbg
);

  skid_state_e   state_q, state_d;
  logic [DW-1:0] main_q, skid_q;
  logic          accept, xfer;
  logic          load_main, load_skid, main_from_skid;

  assign accept    = in_valid & (state_q != SKID_FULL2);
  assign xfer      = out_valid & out_ready;
  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = main_q;
  assign state_dbg = state_q;

  // Next occupancy and register load enables; flush wins over everything.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          state_d   = SKID_FULL1;
          load_main = 1'b1;
        end
      end
      SKID_FULL1: begin
        if (accept && !xfer) begin
          state_d   = SKID_FULL2;
          load_skid = 1'b1;
        end else if (accept && xfer) begin
          load_main = 1'b1;
        end else if (xfer) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL2: begin
        if (xfer) begin
          state_d        = SKID_FULL1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    if (flush) begin
      state_d        = SKID_EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  // State and data registers; main holds its value while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      if (load_main)           main_q <= in_data;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

endmodule

// File: rtl/mux_sel_pipe.sv
// Registered N-way selector: combinational select with out-of-range detect,
// saturating error counter, and a skid buffer carrying {err, word}.
module mux_sel_pipe
  import mux_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               NUM_IN      = 8,
  parameter int               SEL_W       = clog2_min1(NUM_IN),
  parameter logic [31:0]      DEFAULT_VAL = PC_EXC_VECTOR,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int               CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        dout,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        err_cnt
);

  localparam logic [WIDTH-1:0] DEF_WORD = WIDTH'(DEFAULT_VAL);

  logic [WIDTH-1:0] sel_word;
  logic             sel_err;
  logic             accept;
  logic [WIDTH:0]   buf_out;
  skid_state_e      buf_state;

  assign in_ready = (buf_state != SKID_FULL2);
  assign accept   = in_valid & in_ready;
  assign dout     = buf_out[WIDTH-1:0];
  assign out_err  = buf_out[WIDTH];

  // Select decode: any select value with no matching input is an error.
  always_comb begin
    sel_word = DEF_WORD;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_word = din[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  // Saturating count of accepted bad selects, including flushed ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (accept && sel_err && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  mux_skid_buf #(
    .DW        (WIDTH + 1),
    .RESET_VAL ({1'b0, RESET_VAL})
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   ({sel_err, sel_word}),
    .in_valid  (in_valid),
    .out_data  (buf_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_dbg (buf_state)
  );

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe: an 8-way/8-bit-counter instance and a 6-way/2-bit-
// counter instance driven with identical stimulus, each checked against a
// queue model of capacity two.
module tb_mux_sel_pipe;

  localparam int W  = 32;
  localparam int N1 = 8;
  localparam int N2 = 6;
  localparam int C1 = 8;
  localparam int C2 = 2;
  localparam logic [W-1:0] DEF = 32'h0040_0004;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N1*W-1:0] din;
  logic [2:0]      sel;
  logic            in_valid, out_ready, flush;

  logic            in_ready1, out_err1, out_valid1;
  logic [W-1:0]    dout1;
  logic [C1-1:0]   err_cnt1;
  logic            in_ready2, out_err2, out_valid2;
  logic [W-1:0]    dout2;
  logic [C2-1:0]   err_cnt2;

  mux_sel_pipe #(.WIDTH(W), .NUM_IN(N1), .CNT_W(C1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready1), .flush(flush), .dout(dout1), .out_err(out_err1),
    .out_valid(out_valid1), .out_ready(out_ready), .err_cnt(err_cnt1)
  );

  mux_sel_pipe #(.WIDTH(W), .NUM_IN(N2), .CNT_W(C2)) dut2 (
    .clk(clk), .rst_n(rst_n), .din(din[N2*W-1:0]), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready2), .flush(flush), .dout(dout2), .out_err(out_err2),
    .out_valid(out_valid2), .out_ready(out_ready), .err_cnt(err_cnt2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W:0] exp_q1[$];
  logic [W:0] exp_q2[$];
  int ecnt1 = 0;
  int ecnt2 = 0;
  int taken1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference word: {err, data} from the select rules.
  function automatic logic [W:0] ref_word(input int num_in, input logic [2:0] s,
                                          input logic [N1*W-1:0] d);
    if (int'(s) < num_in) return {1'b0, d[int'(s)*W +: W]};
    return {1'b1, DEF};
  endfunction

  // Advance both models by one clock edge using the inputs present at the edge.
  task automatic model_edge();
    bit acc1, acc2, xf1, xf2;
    logic [W:0] w1, w2;
    acc1 = in_valid && (exp_q1.size() < 2);
    xf1  = (exp_q1.size() > 0) && out_ready;
    acc2 = in_valid && (exp_q2.size() < 2);
    xf2  = (exp_q2.size() > 0) && out_ready;
    w1 = ref_word(N1, sel, din);
    w2 = ref_word(N2, sel, din);
    if (xf1) void'(exp_q1.pop_front());
    if (xf2) void'(exp_q2.pop_front());
    if (acc1) exp_q1.push_back(w1);
    if (acc2) exp_q2.push_back(w2);
    if (acc1 && w1[W] && ecnt1 < (1 << C1) - 1) ecnt1++;
    if (acc2 && w2[W] && ecnt2 < (1 << C2) - 1) ecnt2++;
    if (flush) begin
      exp_q1.delete();
      exp_q2.delete();
    end
  endtask

  task automatic check_outputs();
    check("valid1", out_valid1, exp_q1.size() > 0);
    check("ready1", in_ready1, exp_q1.size() < 2);
    check("errcnt1", err_cnt1, ecnt1);
    if (exp_q1.size() > 0) begin
      check("dout1", dout1, exp_q1[0][W-1:0]);
      check("err1", out_err1, exp_q1[0][W]);
    end
    check("valid2", out_valid2, exp_q2.size() > 0);
    check("ready2", in_ready2, exp_q2.size() < 2);
    check("errcnt2", err_cnt2, ecnt2);
    if (exp_q2.size() > 0) begin
      check("dout2", dout2, exp_q2[0][W-1:0]);
      check("err2", out_err2, exp_q2[0][W]);
    end
  endtask

  function automatic logic [N1*W-1:0] rand_din();
    logic [N1*W-1:0] d;
    for (int k = 0; k < N1; k++) d[k*W +: W] = $urandom;
    return d;
  endfunction

  // ---------------- driver ----------------
  // Called just after a falling edge: drive, clock, update model, check.
  task automatic cycle(input logic iv, input logic [2:0] s, input logic ordy,
                       input logic fl, input logic [N1*W-1:0] d);
    in_valid  = iv;
    sel       = s;
    out_ready = ordy;
    flush     = fl;
    din       = d;
    #1;
    if (in_valid && in_ready1) taken1++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_dout1"}, dout1, 0);
    check({tag, "_valid1"}, out_valid1, 0);
    check({tag, "_ready1"}, in_ready1, 1);
    check({tag, "_cnt1"}, err_cnt1, 0);
    check({tag, "_dout2"}, dout2, 0);
    check({tag, "_valid2"}, out_valid2, 0);
    check({tag, "_cnt2"}, err_cnt2, 0);
  endtask

  logic [N1*W-1:0] stream_din;

  initial begin
    in_valid = 1'b0; sel = '0; out_ready = 1'b0; flush = 1'b0; din = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset_state("rst_during");
    repeat (3) @(negedge clk);
    check_reset_state("rst_hold");
    rst_n = 1'b1;
    #1 check_reset_state("rst_after");

    // Out-of-range selects on the 6-way instance, consumer always ready.
    cycle(1, 3'd6, 1, 0, rand_din());
    check("oor_dout", dout2, DEF);
    check("oor_err", out_err2, 1);
    cycle(1, 3'd7, 1, 0, rand_din());
    check("oor_dout7", dout2, DEF);
    check("oor_cnt2", err_cnt2, 2);
    repeat (3) cycle(1, 3'd7, 1, 0, rand_din());
    check("sat_cnt", err_cnt2, 3);
    cycle(0, 3'd0, 1, 0, rand_din());

    // Streaming: one word per cycle, result one cycle after accept.
    for (int k = 0; k < N1; k++) stream_din[k*W +: W] = 32'h1000_0000 + k;
    for (int k = 0; k < N1; k++) begin
      cycle(1, 3'(k), 1, 0, stream_din);
      check("stream_dout", dout1, 32'h1000_0000 + k);
    end
    cycle(0, 3'd0, 1, 0, stream_din);

    // Backpressure: three stalled cycles with input always offered.
    taken1 = 0;
    for (int c = 0; c < 3; c++) begin
      cycle(1, 3'($urandom_range(0, 7)), 0, 0, rand_din());
    end
    check("bp_taken", taken1, 2);
    check("bp_ready", in_ready1, 0);
    cycle(0, 3'd0, 1, 0, rand_din());
    cycle(0, 3'd0, 1, 0, rand_din());
    check("bp_drained", out_valid1, 0);
    check("bp_ready_back", in_ready1, 1);

    // Flush while holding two words, with input offered.
    cycle(1, 3'd1, 0, 0, rand_din());
    cycle(1, 3'd2, 0, 0, rand_din());
    cycle(1, 3'd3, 0, 1, rand_din());
    check("flush_valid", out_valid1, 0);
    check("flush_ready", in_ready1, 1);
    repeat (2) cycle(0, 3'd0, 1, 0, rand_din());

    // Flush in single occupancy with a simultaneous accept and transfer.
    cycle(1, 3'd4, 0, 0, rand_din());
    cycle(1, 3'd5, 1, 1, rand_din());
    check("flush1_valid", out_valid1, 0);
    repeat (2) cycle(0, 3'd0, 1, 0, rand_din());

    // Mid-stream asynchronous reset drops everything.
    cycle(1, 3'd6, 0, 0, rand_din());
    #2 rst_n = 1'b0;
    #1 check_reset_state("rst_mid");
    exp_q1.delete(); exp_q2.delete(); ecnt1 = 0; ecnt2 = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Flushed bad select still counts.
    cycle(1, 3'd7, 1, 1, rand_din());
    check("flush_cnt", err_cnt2, 1);
    check("flush_gone", out_valid2, 0);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
            $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0, rand_din());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
